// File: rtl/vector_mem_sequencer_if.sv
// Connection bundle between the MEM stage, the vector sequencer and the scalar data memory port.
// The master side is the sequencer; the slave side is the pipeline/memory environment.
interface vector_mem_sequencer_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic                    start;
    logic                    is_write;
    logic [ADDR_W-1:0]       base_addr;
    logic [LANES*DATA_W-1:0] wdata_vec;
    logic                    stall;
    logic                    busy;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_ack;
    logic [DATA_W-1:0]       mem_rdata;
    logic [LANES*DATA_W-1:0] rdata_vec;
    logic                    done;

    modport master (
        input  start, is_write, base_addr, wdata_vec, mem_ack, mem_rdata,
        output stall, busy, mem_req, mem_we, mem_addr, mem_wdata, rdata_vec, done
    );

    modport slave (
        output start, is_write, base_addr, wdata_vec, mem_ack, mem_rdata,
        input  stall, busy, mem_req, mem_we, mem_addr, mem_wdata, rdata_vec, done
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Serialises a vector load/store into one scalar memory transaction per lane,
// stalling the pipeline until the whole vector has been transferred.
module vector_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    vector_mem_sequencer_if.master bus
);
    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
    logic [LANES*DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            we_q    <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            we_q    <= we_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        we_d    = we_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    we_d    = bus.is_write;
                    base_d  = bus.base_addr;
                    wdata_d = bus.wdata_vec;
                    lane_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    // Stores leave the gathered load vector untouched.
                    if (!we_q) begin
                        rdata_d[int'(lane_q)*DATA_W +: DATA_W] = bus.mem_rdata;
                    end
                    if (lane_q == LAST_LANE) begin
                        state_d = DONE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs depend on registered state only, never on mem_ack.
    assign bus.mem_req   = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = base_q + {{(ADDR_W-LW){1'b0}}, lane_q};
    assign bus.mem_wdata = wdata_q[int'(lane_q)*DATA_W +: DATA_W];
    assign bus.rdata_vec = rdata_q;
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.stall     = ((state_q == IDLE) && bus.start) || (state_q == ACCESS);
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: table of whole vector operations plus
// hand-written reset and start-hold sequences against a byte-wide memory model.
module tb_vector_mem_sequencer;
    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    typedef struct {
        logic        wr;
        logic [15:0] base;
        logic [31:0] wdata;
        int          waits;
        int          hold;
        int          ncyc;
        logic [31:0] exp_rdata;
        int          exp_done;
        int          exp_stalls;
        int          exp_dones;
    } vec_t;

    logic clk;
    logic rst;
    logic [7:0] mem [0:65535];
    int   wait_cnt;
    int   waits_cfg;
    int   n_cmp;
    int   n_fail;
    vec_t vecs [5];

    vector_mem_sequencer_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vector_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory model: commit a store on an accepted write; count wait cycles for ack pacing.
    task automatic model_update();
        if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        wait_cnt = (bus.mem_req && !bus.mem_ack) ? wait_cnt + 1 : 0;
    endtask

    task automatic run_seq(input vec_t v, input int idx);
        int first_done, dones, stalls, acks, lane;
        logic waiting;
        logic [15:0] held_addr;
        logic [15:0] ea;
        first_done = -1; dones = 0; stalls = 0; acks = 0;
        waiting = 1'b0; held_addr = '0;
        waits_cfg = v.waits;
        wait_cnt = 0;
        bus.is_write  = v.wr;
        bus.base_addr = v.base;
        bus.wdata_vec = v.wdata;
        for (int c = 0; c < v.ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            bus.mem_ack = (wait_cnt >= waits_cfg);
            bus.start   = (c < v.hold);
            #1;
            if (bus.stall) stalls++;
            if (bus.done) begin
                dones++;
                if (first_done < 0) begin
                    first_done = c;
                    check($sformatf("v%0d_stall_in_done", idx), bus.stall, 1'b0);
                end
            end
            if (waiting) begin
                check($sformatf("v%0d_req_held_c%0d", idx, c), bus.mem_req, 1'b1);
                check($sformatf("v%0d_addr_held_c%0d", idx, c), bus.mem_addr, held_addr);
            end
            if (bus.mem_req && bus.mem_ack) begin
                lane = acks % LANES;
                ea = v.base + 16'(lane);
                check($sformatf("v%0d_addr_l%0d", idx, lane), bus.mem_addr, ea);
                check($sformatf("v%0d_we_l%0d", idx, lane), bus.mem_we, v.wr);
                if (v.wr) check($sformatf("v%0d_wdata_l%0d", idx, lane), bus.mem_wdata, v.wdata[lane*8 +: 8]);
                acks++;
            end
            waiting   = bus.mem_req && !bus.mem_ack;
            held_addr = bus.mem_addr;
            model_update();
        end
        bus.start = 1'b0;
        check($sformatf("v%0d_first_done", idx), first_done, v.exp_done);
        check($sformatf("v%0d_done_count", idx), dones, v.exp_dones);
        check($sformatf("v%0d_stall_cycles", idx), stalls, v.exp_stalls);
        check($sformatf("v%0d_ack_count", idx), acks, LANES * v.exp_dones);
        check($sformatf("v%0d_rdata_vec", idx), bus.rdata_vec, v.exp_rdata);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; wait_cnt = 0; waits_cfg = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
        mem[16'hFFFE] = 8'h5A; mem[16'hFFFF] = 8'h6B;
        mem[16'h0000] = 8'h7C; mem[16'h0001] = 8'h8D;

        //          wr    base      wdata         waits hold ncyc exp_rdata     done stalls dones
        vecs[0] = '{1'b0, 16'h0010, 32'h0,        0,    1,   7,   32'h44332211, 5,   5,     1};
        vecs[1] = '{1'b1, 16'h0200, 32'hA4A3A2A1, 0,    1,   7,   32'h44332211, 5,   5,     1};
        vecs[2] = '{1'b0, 16'h0200, 32'h0,        2,    1,   15,  32'hA4A3A2A1, 13,  13,    1};
        vecs[3] = '{1'b0, 16'hFFFE, 32'h0,        0,    1,   7,   32'h8D7C6B5A, 5,   5,     1};
        vecs[4] = '{1'b0, 16'h0010, 32'h0,        0,    10,  13,  32'h44332211, 5,   10,    2};

        rst = 1'b1;
        bus.start = 1'b0; bus.is_write = 1'b0; bus.base_addr = '0;
        bus.wdata_vec = '0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", bus.stall, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_req", bus.mem_req, 1'b0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_addr", bus.mem_addr, 16'h0);
        check("rst_wdata", bus.mem_wdata, 8'h0);
        check("rst_rdata", bus.rdata_vec, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_seq(vecs[i], i);
            @(negedge clk);
        end
        check("store_mem_200", mem[16'h0200], 8'hA1);
        check("store_mem_203", mem[16'h0203], 8'hA4);

        // Reset in the middle of a store, right after lane 1 has been accepted.
        mem[16'h0300] = 8'h00; mem[16'h0301] = 8'h00;
        mem[16'h0302] = 8'h00; mem[16'h0303] = 8'h00;
        waits_cfg = 0; wait_cnt = 0;
        bus.is_write = 1'b1; bus.base_addr = 16'h0300; bus.wdata_vec = 32'hD4D3D2D1;
        bus.mem_ack = 1'b1;
        bus.start = 1'b1;
        #1;
        model_update();
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            check($sformatf("rstseq_addr_c%0d", c), bus.mem_addr, 16'h0300 + 16'(c - 1));
            model_update();
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_stall", bus.stall, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_req", bus.mem_req, 1'b0);
        check("arst_we", bus.mem_we, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_addr", bus.mem_addr, 16'h0);
        check("arst_wdata", bus.mem_wdata, 8'h0);
        check("arst_rdata", bus.rdata_vec, 32'h0);
        bus.start = 1'b1;
        #1;
        check("arst_stall_start", bus.stall, 1'b1);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("arst_mem_300", mem[16'h0300], 8'hD1);
        check("arst_mem_301", mem[16'h0301], 8'hD2);
        check("arst_mem_302", mem[16'h0302], 8'h00);
        check("arst_mem_303", mem[16'h0303], 8'h00);
        @(negedge clk);

        run_seq('{1'b1, 16'h0300, 32'hD4D3D2D1, 0, 1, 7, 32'h0, 5, 5, 1}, 5);
        check("rerun_mem_302", mem[16'h0302], 8'hD3);
        check("rerun_mem_303", mem[16'h0303], 8'hD4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
